mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the IF-stage instruction fetch and the MM-stage load/store.
- Grants one requester at a time and holds the memory command stable for MEM_LAT cycles.
- Returns registered read data with a one-cycle ready pulse.
- Exports a combinational stall that the hazard logic ORs into PC/IFID write-enable.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : requester, memory and status bundle of mem_port_arbiter
// Rev 1.0
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          mm_req;
  logic          mm_we;
  logic [AW-1:0] mm_addr;
  logic [DW-1:0] mm_wdata;
  logic [DW-1:0] mm_rdata;
  logic          mm_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          pipe_stall;
  logic [31:0]   stat_if_wait;
  logic [31:0]   stat_mm_wait;
  logic [31:0]   stat_conflict;

  modport master (
    input  if_req, if_addr, mm_req, mm_we, mm_addr, mm_wdata, mem_rdata,
    output if_rdata, if_ready, mm_rdata, mm_ready,
           mem_en, mem_we, mem_addr, mem_wdata,
           pipe_stall, stat_if_wait, stat_mm_wait, stat_conflict
  );

  modport slave (
    output if_req, if_addr, mm_req, mm_we, mm_addr, mm_wdata, mem_rdata,
    input  if_rdata, if_ready, mm_rdata, mm_ready,
           mem_en, mem_we, mem_addr, mem_wdata,
           pipe_stall, stat_if_wait, stat_mm_wait, stat_conflict
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_port_arbiter : IF/MM arbiter for one fixed-latency memory; optional
// wait/conflict counters under MEM_ARB_STATS_EN.   Rev 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_MM = 1'b1
  } owner_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] mm_rdata_q, mm_rdata_d;

  logic if_ready, mm_ready;
  logic if_elig, mm_elig;
  logic arb_en;

  // The requester being readied this cycle is not eligible again until next cycle.
  always_comb begin
    if_ready = (state_q == RESP) && (owner_q == OWN_IF);
    mm_ready = (state_q == RESP) && (owner_q == OWN_MM);
    if_elig  = bus.if_req & ~if_ready;
    mm_elig  = bus.mm_req & ~mm_ready;
    arb_en   = (state_q == IDLE) || (state_q == RESP);
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    mm_rdata_d = mm_rdata_q;
    case (state_q)
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (owner_q == OWN_MM) mm_rdata_d = bus.mem_rdata;
            else                   if_rdata_d = bus.mem_rdata;
          end
          state_d = RESP;
        end
      end
      default: begin
        // MM holds the older instruction, so it wins ties.
        state_d = IDLE;
        if (mm_elig) begin
          owner_d = OWN_MM;
          addr_d  = bus.mm_addr;
          we_d    = bus.mm_we;
          wdata_d = bus.mm_wdata;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end else if (if_elig) begin
          owner_d = OWN_IF;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      mm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      mm_rdata_q <= mm_rdata_d;
    end
  end

  assign bus.if_ready   = if_ready;
  assign bus.mm_ready   = mm_ready;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.mm_rdata   = mm_rdata_q;
  assign bus.mem_en     = (state_q == BUSY);
  assign bus.mem_we     = (state_q == BUSY) & we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.pipe_stall = if_elig | mm_elig;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_wait_q, stat_if_wait_d;
  logic [31:0] stat_mm_wait_q, stat_mm_wait_d;
  logic [31:0] stat_conflict_q, stat_conflict_d;

  always_comb begin
    stat_if_wait_d  = stat_if_wait_q + 32'(if_elig);
    stat_mm_wait_d  = stat_mm_wait_q + 32'(mm_elig);
    stat_conflict_d = stat_conflict_q + 32'(arb_en & if_elig & mm_elig);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_if_wait_q  <= 32'd0;
      stat_mm_wait_q  <= 32'd0;
      stat_conflict_q <= 32'd0;
    end else begin
      stat_if_wait_q  <= stat_if_wait_d;
      stat_mm_wait_q  <= stat_mm_wait_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end

  assign bus.stat_if_wait  = stat_if_wait_q;
  assign bus.stat_mm_wait  = stat_mm_wait_q;
  assign bus.stat_conflict = stat_conflict_q;
`else
  logic unused_arb_en;
  assign unused_arb_en     = arb_en;
  assign bus.stat_if_wait  = 32'd0;
  assign bus.stat_mm_wait  = 32'd0;
  assign bus.stat_conflict = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed scenarios plus randomized IF/MM traffic
// against a transaction-level memory model.   Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int BOUND   = 3 * (MEM_LAT + 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] tally_if = 32'd0;
  logic [31:0] tally_mm = 32'd0;
  logic [31:0] exp_mm_rdata;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h9E37_79B9;
  endfunction

  function automatic logic [31:0] env_read(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counters see the cycle that is ending; a low rst_n at that edge clears them.
  task automatic account();
    if (!rst_n) begin
      tally_if = 32'd0;
      tally_mm = 32'd0;
    end else begin
      if (bus.if_req && !bus.if_ready) tally_if++;
      if (bus.mm_req && !bus.mm_ready) tally_mm++;
    end
  endtask

  task automatic tick();
    account();
    @(posedge clk);
    #2;
  endtask

  // Memory model: answers the current address and commits stores.
  task automatic settle();
    #1;
    bus.mem_rdata = env_read(bus.mem_addr);
    if (bus.mem_en && bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
  endtask

  task automatic check_waits(input string tag);
`ifdef MEM_ARB_STATS_EN
    check({tag, "_if_wait"}, bus.stat_if_wait, tally_if);
    check({tag, "_mm_wait"}, bus.stat_mm_wait, tally_mm);
`else
    check({tag, "_if_wait"}, bus.stat_if_wait, 32'd0);
    check({tag, "_mm_wait"}, bus.stat_mm_wait, 32'd0);
`endif
  endtask

  task automatic check_conflict(input string tag, input logic [31:0] n);
`ifdef MEM_ARB_STATS_EN
    check(tag, bus.stat_conflict, n);
`else
    check(tag, bus.stat_conflict, 32'd0 & n);
`endif
  endtask

  logic        if_pend, mm_pend, mm_exp_we, seen;
  logic [31:0] if_exp_addr, mm_exp_addr, mm_exp_wdata;
  int          if_wait, mm_wait, if_cool, run_len;
  logic [31:0] run_addr;

  initial begin
    env_mem[32'h0040_0000] = 32'h2408_0005;
    ref_mem[32'h0040_0000] = 32'h2408_0005;
    bus.mem_rdata = 32'd0;
    bus.if_req = 1'b1;  bus.if_addr = 32'h0040_0000;
    bus.mm_req = 1'b1;  bus.mm_we = 1'b0;
    bus.mm_addr = 32'h1001_0000;  bus.mm_wdata = 32'd0;

    // Reset with both requests high
    tick(); settle();
    tick(); settle();
    check("rst_mem_en",    32'(bus.mem_en), 32'd0);
    check("rst_mem_we",    32'(bus.mem_we), 32'd0);
    check("rst_mem_addr",  bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_if_ready",  32'(bus.if_ready), 32'd0);
    check("rst_mm_ready",  32'(bus.mm_ready), 32'd0);
    check("rst_if_rdata",  bus.if_rdata, 32'd0);
    check("rst_mm_rdata",  bus.mm_rdata, 32'd0);
    check_waits("rst");
    check_conflict("rst_conflict", 32'd0);
    tick(); rst_n = 1'b1; settle();
    check("rel_c0_mem_en", 32'(bus.mem_en), 32'd0);
    tick(); bus.if_req = 1'b0; bus.mm_req = 1'b0; settle();
    check("rel_c1_mem_en",   32'(bus.mem_en), 32'd1);
    check("rel_c1_mem_addr", bus.mem_addr, 32'h1001_0000);
    check_conflict("rel_conflict", 32'd1);
    tick(); settle();
    tick(); settle();
    exp_mm_rdata = ref_read(32'h1001_0000);
    check("rel_mm_ready", 32'(bus.mm_ready), 32'd1);
    check("rel_mm_rdata", bus.mm_rdata, exp_mm_rdata);
    tick(); settle();

    // Single fetch
    tick(); bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000; settle();
    check("fetch_c0_stall",  32'(bus.pipe_stall), 32'd1);
    check("fetch_c0_mem_en", 32'(bus.mem_en), 32'd0);
    for (int k = 1; k <= MEM_LAT; k++) begin
      tick(); settle();
      check("fetch_busy_en",    32'(bus.mem_en), 32'd1);
      check("fetch_busy_addr",  bus.mem_addr, 32'h0040_0000);
      check("fetch_busy_stall", 32'(bus.pipe_stall), 32'd1);
      check("fetch_busy_ready", 32'(bus.if_ready), 32'd0);
    end
    tick(); settle();
    check("fetch_ready",  32'(bus.if_ready), 32'd1);
    check("fetch_rdata",  bus.if_rdata, 32'h2408_0005);
    check("fetch_stall0", 32'(bus.pipe_stall), 32'd0);
    check("fetch_resp_en", 32'(bus.mem_en), 32'd0);
    tick(); bus.if_req = 1'b0; settle();
    check("fetch_after_en", 32'(bus.mem_en), 32'd0);
    check_waits("fetch");

    // Conflict: MM served first, IF right after
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h0040_0004;
    bus.mm_req = 1'b1; bus.mm_we = 1'b0; bus.mm_addr = 32'h1001_0004;
    settle();
    check("conf_c0_en", 32'(bus.mem_en), 32'd0);
    tick(); settle();
    check("conf_c1_addr", bus.mem_addr, 32'h1001_0004);
    check("conf_c1_we",   32'(bus.mem_we), 32'd0);
    check_conflict("conf_count", 32'd2);
    tick(); settle();
    tick(); settle();
    exp_mm_rdata = ref_read(32'h1001_0004);
    check("conf_mm_ready", 32'(bus.mm_ready), 32'd1);
    check("conf_if_quiet", 32'(bus.if_ready), 32'd0);
    check("conf_mm_rdata", bus.mm_rdata, exp_mm_rdata);
    check("conf_c3_stall", 32'(bus.pipe_stall), 32'd1);
    tick(); bus.mm_req = 1'b0; settle();
    check("conf_c4_en",   32'(bus.mem_en), 32'd1);
    check("conf_c4_addr", bus.mem_addr, 32'h0040_0004);
    tick(); settle();
    tick(); settle();
    check("conf_if_ready", 32'(bus.if_ready), 32'd1);
    check("conf_mm_quiet", 32'(bus.mm_ready), 32'd0);
    check("conf_if_rdata", bus.if_rdata, ref_read(32'h0040_0004));
    tick(); bus.if_req = 1'b0; settle();
    check_waits("conf");

    // Store with request fields changed after grant
    tick();
    bus.mm_req = 1'b1; bus.mm_we = 1'b1;
    bus.mm_addr = 32'h1001_0008; bus.mm_wdata = 32'hDEAD_BEEF;
    settle();
    for (int k = 1; k <= MEM_LAT; k++) begin
      tick();
      if (k == 1) begin
        bus.mm_req = 1'b0; bus.mm_we = 1'b0;
        bus.mm_addr = 32'h1001_0010; bus.mm_wdata = 32'h1111_1111;
      end
      settle();
      check("st_busy_en",    32'(bus.mem_en), 32'd1);
      check("st_busy_we",    32'(bus.mem_we), 32'd1);
      check("st_busy_addr",  bus.mem_addr, 32'h1001_0008);
      check("st_busy_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    end
    tick(); settle();
    ref_mem[32'h1001_0008] = 32'hDEAD_BEEF;
    check("st_mm_ready", 32'(bus.mm_ready), 32'd1);
    check("st_mm_rdata", bus.mm_rdata, exp_mm_rdata);
    check("st_resp_we",  32'(bus.mem_we), 32'd0);

    // Fetch flushed after grant
    tick(); bus.if_req = 1'b1; bus.if_addr = 32'h0040_0008; settle();
    tick(); bus.if_req = 1'b0; settle();
    check("flush_c1_en",    32'(bus.mem_en), 32'd1);
    check("flush_c1_stall", 32'(bus.pipe_stall), 32'd0);
    tick(); settle();
    tick(); settle();
    check("flush_ready", 32'(bus.if_ready), 32'd1);
    check("flush_rdata", bus.if_rdata, ref_read(32'h0040_0008));
    tick(); settle();
    check("flush_c4_en",    32'(bus.mem_en), 32'd0);
    check("flush_c4_ready", 32'(bus.if_ready), 32'd0);

    // Reset in the middle of a fetch
    tick(); bus.if_req = 1'b1; bus.if_addr = 32'h0040_000C; settle();
    tick(); bus.if_req = 1'b0; rst_n = 1'b0; settle();
    check("rstmid_c1_en", 32'(bus.mem_en), 32'd1);
    tick(); rst_n = 1'b1; settle();
    check("rstmid_c2_en",    32'(bus.mem_en), 32'd0);
    check("rstmid_if_rdata", bus.if_rdata, 32'd0);
    check_conflict("rstmid_conflict", 32'd0);
    seen = bus.if_ready | bus.mm_ready;
    repeat (6) begin
      tick(); settle();
      seen = seen | bus.if_ready | bus.mm_ready;
    end
    check("rstmid_no_ready", 32'(seen), 32'd0);
    check_waits("rstmid");
    exp_mm_rdata = 32'd0;

    // Randomized traffic
    if_pend = 1'b0; mm_pend = 1'b0; mm_exp_we = 1'b0;
    if_wait = 0; mm_wait = 0; if_cool = 0; run_len = 0; run_addr = 32'd0;
    if_exp_addr = 32'd0; mm_exp_addr = 32'd0; mm_exp_wdata = 32'd0;
    for (int c = 0; c < 2500; c++) begin
      tick();
      if (!if_pend) begin
        bus.if_req = 1'b0;
        if (if_cool > 0) begin
          if_cool--;
        end else if (c < 2450 && $urandom_range(2) == 0) begin
          if_pend = 1'b1; if_wait = 0;
          if_exp_addr = 32'h0040_0000 + ($urandom_range(255) << 2);
          bus.if_req = 1'b1; bus.if_addr = if_exp_addr;
        end
      end else if ($urandom_range(40) == 0) begin
        if_pend = 1'b0; bus.if_req = 1'b0; if_cool = 2 * MEM_LAT + 4;
      end
      if (!mm_pend) begin
        bus.mm_req = 1'b0;
        if (c < 2450 && $urandom_range(1) == 0) begin
          mm_pend = 1'b1; mm_wait = 0;
          mm_exp_we = 1'($urandom_range(1));
          mm_exp_addr = 32'h1001_0000 + ($urandom_range(7) << 2);
          mm_exp_wdata = $urandom();
          bus.mm_req = 1'b1; bus.mm_we = mm_exp_we;
          bus.mm_addr = mm_exp_addr; bus.mm_wdata = mm_exp_wdata;
        end
      end
      settle();

      check("rnd_ready_excl", 32'(bus.if_ready & bus.mm_ready), 32'd0);
      check("rnd_pipe_stall", 32'(bus.pipe_stall),
            32'((bus.if_req & ~bus.if_ready) | (bus.mm_req & ~bus.mm_ready)));
      if (bus.mem_en) begin
        if (run_len == 0) run_addr = bus.mem_addr;
        else check("rnd_addr_stable", bus.mem_addr, run_addr);
        run_len++;
      end else if (run_len != 0) begin
        check("rnd_mem_en_len", 32'(run_len), 32'(MEM_LAT));
        run_len = 0;
      end

      if (if_pend && bus.if_ready) begin
        check("rnd_if_rdata", bus.if_rdata, ref_read(if_exp_addr));
        if_pend = 1'b0;
      end else if (if_pend) begin
        if_wait++;
        if (if_wait > BOUND) begin
          check("rnd_if_timeout", 32'(if_wait), 32'(BOUND));
          if_pend = 1'b0; if_cool = 2 * MEM_LAT + 4;
        end
      end else if (if_cool == 0) begin
        check("rnd_if_ready_idle", 32'(bus.if_ready), 32'd0);
      end

      if (mm_pend && bus.mm_ready) begin
        if (mm_exp_we) begin
          ref_mem[mm_exp_addr] = mm_exp_wdata;
          check("rnd_mm_rdata_st", bus.mm_rdata, exp_mm_rdata);
        end else begin
          exp_mm_rdata = ref_read(mm_exp_addr);
          check("rnd_mm_rdata_ld", bus.mm_rdata, exp_mm_rdata);
        end
        mm_pend = 1'b0;
      end else if (mm_pend) begin
        mm_wait++;
        if (mm_wait > BOUND) begin
          check("rnd_mm_timeout", 32'(mm_wait), 32'(BOUND));
          mm_pend = 1'b0;
        end
      end else begin
        check("rnd_mm_ready_idle", 32'(bus.mm_ready), 32'd0);
      end
    end
    check("rnd_if_drained", 32'(if_pend), 32'd0);
    check("rnd_mm_drained", 32'(mm_pend), 32'd0);
    check_waits("rnd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
